// File: rtl/input_debouncer.sv
// input_debouncer
// Synchronizes a noisy asynchronous level (e.g. a pushbutton), qualifies
// each new level over DB_CYCLES consecutive synchronized samples, and emits
// one-cycle rise/fall strobes on accepted edges. Rejected excursions are
// counted in a saturating glitch counter.
//
// state     | meaning
// ----------+---------------------------------------------------------
// STABLE_LO | accepted level is 0, waiting for s2=1 while enabled
// CHK_HI    | counting consecutive s2=1 samples toward accepting a 1
// STABLE_HI | accepted level is 1, waiting for s2=0 while enabled
// CHK_LO    | counting consecutive s2=0 samples toward accepting a 0
module input_debouncer #(
  parameter int DB_CYCLES = 4,
  parameter int GC_W      = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            raw_in,
  input  logic            en,
  input  logic            glitch_clr,
  output logic            clean_out,
  output logic            rise_pulse,
  output logic            fall_pulse,
  output logic [GC_W-1:0] glitch_cnt
);

  // Qualification counter only ever needs to reach DB_CYCLES-1.
  localparam int             CNT_W   = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [GC_W-1:0]  GC_MAX  = {GC_W{1'b1}};

  localparam logic [1:0] STABLE_LO = 2'd0;
  localparam logic [1:0] CHK_HI    = 2'd1;
  localparam logic [1:0] STABLE_HI = 2'd2;
  localparam logic [1:0] CHK_LO    = 2'd3;

  logic             s1;
  logic             s2;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             rise_nxt;
  logic             fall_nxt;
  logic             glitch;

  // Two-flop synchronizer; runs regardless of en.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw_in;
      s2 <= s1;
    end
  end

  // Next-state, counter, strobe and glitch decisions from the synchronized sample.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    glitch    = 1'b0;
    case (state)
      STABLE_LO: begin
        if (en && s2) begin
          state_nxt = CHK_HI;
          cnt_nxt   = CNT_ONE;
        end
      end
      CHK_HI: begin
        if (!en) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
        end else if (!s2) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
          glitch    = 1'b1;
        end else if (cnt == CNT_MAX) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = '0;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (en && !s2) begin
          state_nxt = CHK_LO;
          cnt_nxt   = CNT_ONE;
        end
      end
      CHK_LO: begin
        if (!en) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = '0;
        end else if (s2) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = '0;
          glitch    = 1'b1;
        end else if (cnt == CNT_MAX) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = STABLE_LO;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and strobe registers; strobes land with the new level.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= STABLE_LO;
      cnt        <= '0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
    end
  end

  // Saturating glitch counter; a clear beats a coincident glitch.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      glitch_cnt <= '0;
    end else if (glitch_clr) begin
      glitch_cnt <= '0;
    end else if (glitch && (glitch_cnt != GC_MAX)) begin
      glitch_cnt <= glitch_cnt + 1'b1;
    end
  end

  // Decoded from state so reset drops the level without waiting for a clock.
  always_comb begin
    clean_out = (state == STABLE_HI) || (state == CHK_LO);
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: directed scenarios followed by randomized
// levels, all compared against a run-length reference model. Two instances
// share stimulus: default widths, and GC_W=2 for glitch saturation.
module tb_input_debouncer;

  localparam int DB = 4;

  logic       CLK = 1'b0;
  logic       rst = 1'b0;
  logic       raw_in = 1'b0;
  logic       en = 1'b0;
  logic       glitch_clr = 1'b0;

  logic       clean_a, rise_a, fall_a;
  logic [7:0] gc_a;
  logic       clean_b, rise_b, fall_b;
  logic [1:0] gc_b;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic m_s1, m_s2, m_clean, m_rise, m_fall;
  int   m_run, m_gc8, m_gc2;

  input_debouncer #(.DB_CYCLES(DB), .GC_W(8)) dut_a (
    .CLK(CLK), .RST(rst), .raw_in(raw_in), .en(en), .glitch_clr(glitch_clr),
    .clean_out(clean_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .glitch_cnt(gc_a)
  );

  input_debouncer #(.DB_CYCLES(DB), .GC_W(2)) dut_b (
    .CLK(CLK), .RST(rst), .raw_in(raw_in), .en(en), .glitch_clr(glitch_clr),
    .clean_out(clean_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .glitch_cnt(gc_b)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_clean = 0; m_rise = 0; m_fall = 0;
    m_run = 0; m_gc8 = 0; m_gc2 = 0;
  endtask

  // A new level is accepted once DB consecutive enabled samples disagree
  // with the current level; an interrupted run while enabled is a glitch.
  task automatic model_edge();
    bit g;
    g = 0;
    if (!rst) begin
      model_reset();
      return;
    end
    m_rise = 0;
    m_fall = 0;
    if (en && (m_s2 != m_clean)) begin
      m_run++;
      if (m_run == DB) begin
        m_clean = !m_clean;
        m_run   = 0;
        if (m_clean) m_rise = 1; else m_fall = 1;
      end
    end else begin
      if (en && m_run > 0) g = 1;
      m_run = 0;
    end
    if (glitch_clr) begin
      m_gc8 = 0;
      m_gc2 = 0;
    end else if (g) begin
      if (m_gc8 < 255) m_gc8++;
      if (m_gc2 < 3) m_gc2++;
    end
    m_s2 = m_s1;
    m_s1 = raw_in;
  endtask

  task automatic compare_all();
    chk("clean_a", 8'(clean_a), 8'(m_clean));
    chk("rise_a",  8'(rise_a),  8'(m_rise));
    chk("fall_a",  8'(fall_a),  8'(m_fall));
    chk("gc_a",    gc_a,        8'(m_gc8));
    chk("clean_b", 8'(clean_b), 8'(m_clean));
    chk("rise_b",  8'(rise_b),  8'(m_rise));
    chk("fall_b",  8'(fall_b),  8'(m_fall));
    chk("gc_b",    8'(gc_b),    8'(m_gc2));
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      model_edge();
      #1;
      compare_all();
    end
  endtask

  // raw high for 3 edges, then low; glitch lands on the 6th edge
  task automatic short_glitch(input logic clr_on_glitch);
    raw_in = 1'b1;
    step(3);
    raw_in = 1'b0;
    step(2);
    glitch_clr = clr_on_glitch;
    step(1);
    glitch_clr = 1'b0;
    step(2);
  endtask

  initial begin
    int gc_before;
    int edges;
    int hold;
    model_reset();

    // reset state
    #2;
    compare_all();
    step(3);
    #2;
    rst = 1'b1;
    en  = 1'b1;
    step(2);

    // clean rise: level appears exactly DB+2 edges after first sampling edge
    raw_in = 1'b1;
    step(5);
    chk("rise_not_early", 8'(clean_a), 8'd0);
    step(1);
    chk("rise_latency_clean", 8'(clean_a), 8'd1);
    chk("rise_latency_pulse", 8'(rise_a), 8'd1);
    step(1);
    chk("rise_one_cycle", 8'(rise_a), 8'd0);

    // clean fall
    gc_before = int'(gc_a);
    raw_in = 1'b0;
    step(6);
    chk("fall_latency_clean", 8'(clean_a), 8'd0);
    chk("fall_latency_pulse", 8'(fall_a), 8'd1);
    step(1);
    chk("fall_one_cycle", 8'(fall_a), 8'd0);
    chk("fall_gc_unchanged", gc_a, 8'(gc_before));

    // short glitch
    short_glitch(1'b0);
    chk("glitch_clean_low", 8'(clean_a), 8'd0);
    chk("glitch_count_one", gc_a, 8'd1);

    // saturation at GC_W=2, then clear coinciding with a glitch
    for (int k = 0; k < 4; k++) short_glitch(1'b0);
    chk("sat_b", 8'(gc_b), 8'd3);
    chk("count_a_five", gc_a, 8'd5);
    short_glitch(1'b1);
    chk("clr_wins_a", gc_a, 8'd0);
    chk("clr_wins_b", 8'(gc_b), 8'd0);

    // enable drop in CHK_HI with cnt=2
    raw_in = 1'b1;
    step(4);
    en = 1'b0;
    step(1);
    chk("endrop_clean", 8'(clean_a), 8'd0);
    chk("endrop_gc", gc_a, 8'd0);
    step(3);
    en = 1'b1;
    edges = 0;
    while (rise_a !== 1'b1 && edges < 20) begin
      step(1);
      edges++;
    end
    chk("reenable_edges", 8'(edges), 8'(DB));

    // async reset between edges while clean_out=1
    step(2);
    chk("pre_reset_high", 8'(clean_a), 8'd1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    compare_all();
    step(2);
    chk("reset_no_fall", 8'(fall_a), 8'd0);

    // release with raw_in high: normal rise
    #2;
    rst = 1'b1;
    step(8);
    chk("post_reset_rise", 8'(clean_a), 8'd1);

    // randomized levels, enable drops and clears
    for (int seg = 0; seg < 120; seg++) begin
      raw_in = 1'($urandom_range(0, 1));
      hold   = int'($urandom_range(1, 9));
      for (int j = 0; j < hold; j++) begin
        en         = ($urandom_range(0, 9) != 0);
        glitch_clr = ($urandom_range(0, 29) == 0);
        step(1);
      end
    end
    glitch_clr = 1'b0;
    en = 1'b1;
    step(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim did not finish");
    $fatal(1, "timeout");
  end

endmodule
